// File: rtl/ctrl_pipeline_if.sv
// Control-pipeline bundle: D-stage instruction and E-stage hazard controls in,
// per-stage control signals out.
interface ctrl_pipeline_if;
    logic [31:0] InstrD;
    logic        StallE;
    logic        FlushE;
    logic [4:0]  ALUControlE;
    logic        ALUSrcE;
    logic        SrcAsrcE;
    logic        BranchE;
    logic        JumpE;
    logic        jumpRegE;
    logic [2:0]  ImmSrcD;
    logic [2:0]  funct3E;
    logic        MDBusy;
    logic        RegWriteM;
    logic        MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  funct3M;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic        IllegalD;
    logic        IllegalW;

    modport master (
        output InstrD, StallE, FlushE,
        input  ALUControlE, ALUSrcE, SrcAsrcE, BranchE, JumpE, jumpRegE, ImmSrcD,
               funct3E, MDBusy, RegWriteM, MemWriteM, ResultSrcM, funct3M,
               RegWriteW, ResultSrcW, IllegalD, IllegalW
    );

    modport slave (
        input  InstrD, StallE, FlushE,
        output ALUControlE, ALUSrcE, SrcAsrcE, BranchE, JumpE, jumpRegE, ImmSrcD,
               funct3E, MDBusy, RegWriteM, MemWriteM, ResultSrcM, funct3M,
               RegWriteW, ResultSrcW, IllegalD, IllegalW
    );
endinterface

// File: rtl/ctrl_pipeline.sv
// RV32 control unit: D-stage decode with E/M/W control registers and illegal detect.
// Define RV_M_EXT_EN to decode the M extension and build the multi-cycle divide sequencer.
module ctrl_pipeline #(
    parameter int DIV_LATENCY = 32,
    parameter int CNT_W       = $clog2(DIV_LATENCY + 1)
) (
    input logic            clk,
    input logic            reset,
    ctrl_pipeline_if.slave cp
);
    localparam logic [4:0] ALU_ADD   = 5'b00000;
    localparam logic [4:0] ALU_SUB   = 5'b00001;
    localparam logic [4:0] ALU_AND   = 5'b00010;
    localparam logic [4:0] ALU_OR    = 5'b00011;
    localparam logic [4:0] ALU_XOR   = 5'b00100;
    localparam logic [4:0] ALU_SLT   = 5'b00101;
    localparam logic [4:0] ALU_SLTU  = 5'b00110;
    localparam logic [4:0] ALU_SLL   = 5'b00111;
    localparam logic [4:0] ALU_SRL   = 5'b01000;
    localparam logic [4:0] ALU_SRA   = 5'b01001;
    localparam logic [4:0] ALU_PASSB = 5'b01010;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;   // 00 ALU, 01 memory, 10 PC+4
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       jump_reg;
        logic [4:0] alu_ctrl;
        logic       alu_src;
        logic       srca_src;
        logic [2:0] funct3;
        logic       illegal;
        logic       is_div;
    } ctrl_e_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic [1:0] result_src;
        logic [2:0] funct3;
        logic       illegal;
    } ctrl_m_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       illegal;
    } ctrl_w_t;

    function automatic logic [4:0] alu_op(input logic [2:0] f3, input logic alt);
        logic [4:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    assign opcode = cp.InstrD[6:0];
    assign f3     = cp.InstrD[14:12];
    assign f7     = cp.InstrD[31:25];

    ctrl_e_t    dec;
    logic [2:0] imm_src;

    always_comb begin
        dec     = '0;
        imm_src = 3'b000;
        case (opcode)
            OP_LOAD: begin
                dec.reg_write  = 1'b1;
                dec.result_src = 2'b01;
                dec.alu_src    = 1'b1;
            end
            OP_STORE: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                imm_src       = 3'b001;
            end
            OP_R: begin
                dec.reg_write = 1'b1;
                dec.alu_ctrl  = alu_op(f3, f7[5]);
`ifdef RV_M_EXT_EN
                if (f7 == 7'b0000001) begin
                    dec.alu_ctrl = {2'b10, f3};
                    dec.is_div   = f3[2];
                end
`else
                if (f7 == 7'b0000001) dec.illegal = 1'b1;
`endif
            end
            OP_IMM: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                // only shifts use bit 30; addi never becomes a subtract
                dec.alu_ctrl  = alu_op(f3, f7[5] & (f3 == 3'b101));
            end
            OP_BRANCH: begin
                dec.branch   = 1'b1;
                dec.alu_ctrl = ALU_SUB;
                imm_src      = 3'b010;
            end
            OP_JAL: begin
                dec.reg_write  = 1'b1;
                dec.jump       = 1'b1;
                dec.result_src = 2'b10;
                imm_src        = 3'b011;
            end
            OP_JALR: begin
                dec.reg_write  = 1'b1;
                dec.jump       = 1'b1;
                dec.jump_reg   = 1'b1;
                dec.result_src = 2'b10;
                dec.alu_src    = 1'b1;
            end
            OP_LUI: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_ctrl  = ALU_PASSB;
                imm_src       = 3'b100;
            end
            OP_AUIPC: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.srca_src  = 1'b1;
                imm_src       = 3'b100;
            end
            default: dec.illegal = 1'b1;
        endcase
        dec.funct3 = f3;
        if (dec.illegal) begin
            dec         = '0;
            dec.illegal = 1'b1;
            imm_src     = 3'b000;
        end
    end

    ctrl_e_t e_d, e_q;
    ctrl_m_t m_d, m_q;
    ctrl_w_t w_d, w_q;
    logic    md_busy;

    always_comb begin
        e_d = e_q;
        if (cp.FlushE)                    e_d = '0;
        else if (!cp.StallE && !md_busy) e_d = dec;

        m_d = '0;
        if (!md_busy) begin
            m_d.reg_write  = e_q.reg_write;
            m_d.mem_write  = e_q.mem_write;
            m_d.result_src = e_q.result_src;
            m_d.funct3     = e_q.funct3;
            m_d.illegal    = e_q.illegal;
        end

        w_d.reg_write  = m_q.reg_write;
        w_d.result_src = m_q.result_src;
        w_d.illegal    = m_q.illegal;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
            w_q <= w_d;
        end
    end

`ifdef RV_M_EXT_EN
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        md_busy = 1'b0;
        case (state_q)
            IDLE: begin
                md_busy = e_q.is_div;
                if (e_q.is_div && !cp.FlushE) begin
                    state_d = BUSY;
                    cnt_d   = CNT_W'(DIV_LATENCY - 1);
                end
            end
            BUSY: begin
                md_busy = 1'b1;
                if (cp.FlushE)          state_d = IDLE;
                else if (cnt_q != '0)   cnt_d   = cnt_q - CNT_W'(1);
                else                    state_d = DONE;
            end
            // E releases the finished divide this cycle; MDBusy is already low
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
`else
    assign md_busy = 1'b0;
`endif

    logic unused_bits;
    assign unused_bits = ^{cp.InstrD[24:15], cp.InstrD[11:7], e_q.is_div};

    assign cp.ImmSrcD     = imm_src;
    assign cp.IllegalD    = dec.illegal;
    assign cp.ALUControlE = e_q.alu_ctrl;
    assign cp.ALUSrcE     = e_q.alu_src;
    assign cp.SrcAsrcE    = e_q.srca_src;
    assign cp.BranchE     = e_q.branch;
    assign cp.JumpE       = e_q.jump;
    assign cp.jumpRegE    = e_q.jump_reg;
    assign cp.funct3E     = e_q.funct3;
    assign cp.MDBusy      = md_busy;
    assign cp.RegWriteM   = m_q.reg_write;
    assign cp.MemWriteM   = m_q.mem_write;
    assign cp.ResultSrcM  = m_q.result_src;
    assign cp.funct3M     = m_q.funct3;
    assign cp.RegWriteW   = w_q.reg_write;
    assign cp.ResultSrcW  = w_q.result_src;
    assign cp.IllegalW    = w_q.illegal;
endmodule

// File: tb/tb_ctrl_pipeline.sv
// Scoreboard bench for ctrl_pipeline: an instruction-level reference model predicts
// every cycle's outputs; a negedge monitor pops and compares.
module tb_ctrl_pipeline;
    localparam int L = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ctrl_pipeline_if cpif();
    ctrl_pipeline #(.DIV_LATENCY(L)) dut (.clk(clk), .reset(reset), .cp(cpif));

`ifdef RV_M_EXT_EN
    localparam bit MEXT = 1'b1;
`else
    localparam bit MEXT = 1'b0;
`endif

    // ALU op per funct3: ADD SLL SLT SLTU XOR SRL OR AND; SUB/SRA are the next code up
    localparam logic [7:0][4:0] BASE = {5'd2, 5'd3, 5'd8, 5'd4, 5'd6, 5'd5, 5'd7, 5'd0};

    typedef struct packed {
        logic rw; logic mw; logic [1:0] rs; logic br; logic j; logic jr;
        logic [4:0] alu; logic asrc; logic pcsrc; logic [2:0] f3; logic ill; logic dv;
    } ctl_t;

    typedef struct packed {
        logic illd; logic [2:0] imm; logic [4:0] alu; logic asrc; logic pcsrc;
        logic br; logic j; logic jr; logic [2:0] f3e; logic busy;
        logic rwm; logic mwm; logic [1:0] rsm; logic [2:0] f3m;
        logic rww; logic [1:0] rsw; logic illw;
    } obs_t;

    obs_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    ctl_t        e, mm, ww;
    int          age;
    logic [31:0] cur_ins;
    logic        cur_st, cur_fl, cur_rst;

    function automatic ctl_t ref_decode(input logic [31:0] ins, output logic [2:0] imm);
        ctl_t       c;
        logic [2:0] f3;
        logic       alt;
        c   = '0;
        imm = 3'd0;
        f3  = ins[14:12];
        c.f3 = f3;
        case (ins[6:0])
            7'h03: begin c.rw = 1; c.rs = 2'd1; c.asrc = 1; end
            7'h23: begin c.mw = 1; c.asrc = 1; imm = 3'd1; end
            7'h33: begin
                c.rw = 1;
                if (ins[31:25] == 7'd1) begin
                    if (MEXT) begin c.alu = {2'b10, f3}; c.dv = f3[2]; end
                    else c.ill = 1;
                end else begin
                    alt   = ins[30] && (f3 == 3'd0 || f3 == 3'd5);
                    c.alu = BASE[f3] + {4'd0, alt};
                end
            end
            7'h13: begin
                c.rw = 1; c.asrc = 1;
                alt   = ins[30] && (f3 == 3'd5);
                c.alu = BASE[f3] + {4'd0, alt};
            end
            7'h63: begin c.br = 1; c.alu = 5'd1; imm = 3'd2; end
            7'h6F: begin c.rw = 1; c.j = 1; c.rs = 2'd2; imm = 3'd3; end
            7'h67: begin c.rw = 1; c.j = 1; c.jr = 1; c.rs = 2'd2; c.asrc = 1; end
            7'h37: begin c.rw = 1; c.asrc = 1; c.alu = 5'd10; imm = 3'd4; end
            7'h17: begin c.rw = 1; c.asrc = 1; c.pcsrc = 1; imm = 3'd4; end
            default: c.ill = 1;
        endcase
        if (c.ill) begin c = '0; c.ill = 1; imm = 3'd0; end
        return c;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r, ins;
        logic [2:0]  f3;
        r  = $urandom();
        f3 = r[14:12];
        case ($urandom_range(0, 10))
            0:  ins = {r[31:15], 3'b010, r[11:7], 7'h03};
            1:  ins = {r[31:15], 3'b010, r[11:7], 7'h23};
            2:  ins = {1'b0, (f3 == 3'd0 || f3 == 3'd5) ? r[30] : 1'b0, 5'd0, r[24:15], f3, r[11:7], 7'h33};
            3:  ins = (f3 == 3'd1 || f3 == 3'd5) ?
                      {1'b0, (f3 == 3'd5) & r[30], 5'd0, r[24:15], f3, r[11:7], 7'h13} :
                      {r[31:15], f3, r[11:7], 7'h13};
            4:  ins = {r[31:15], f3, r[11:7], 7'h63};
            5:  ins = {r[31:7], 7'h6F};
            6:  ins = {r[31:15], 3'b000, r[11:7], 7'h67};
            7:  ins = {r[31:7], 7'h37};
            8:  ins = {r[31:7], 7'h17};
            9:  ins = {7'b0000001, r[24:15], f3, r[11:7], 7'h33};
            default: ins = r;
        endcase
        return ins;
    endfunction

    function automatic void model_clear();
        e = '0; mm = '0; ww = '0; age = 0;
    endfunction

    function automatic void model_step();
        logic        busy;
        logic [2:0]  imm;
        if (cur_rst) begin model_clear(); return; end
        busy = e.dv && (age <= L);
        ww = mm;
        mm = busy ? '0 : e;
        if (cur_fl) begin e = '0; age = 0; end
        else if (cur_st || busy) age++;
        else begin e = ref_decode(cur_ins, imm); age = 0; end
    endfunction

    task automatic cycle(input logic [31:0] ins, input logic st, input logic fl, input logic rs);
        ctl_t       dd;
        logic [2:0] imm;
        obs_t       o;
        @(posedge clk);
        model_step();
        #1;
        // holding a divide through its release cycle would re-arm it; keep stalls off divides
        if (e.dv) st = 1'b0;
        cur_ins = ins; cur_st = st; cur_fl = fl; cur_rst = rs;
        cpif.InstrD = ins; cpif.StallE = st; cpif.FlushE = fl; reset = rs;
        if (rs) model_clear();
        dd = ref_decode(ins, imm);
        o.illd = dd.ill;   o.imm = imm;
        o.alu = e.alu;     o.asrc = e.asrc; o.pcsrc = e.pcsrc;
        o.br = e.br;       o.j = e.j;       o.jr = e.jr;  o.f3e = e.f3;
        o.busy = e.dv && (age <= L);
        o.rwm = mm.rw;     o.mwm = mm.mw;   o.rsm = mm.rs; o.f3m = mm.f3;
        o.rww = ww.rw;     o.rsw = ww.rs;   o.illw = ww.ill;
        exp_q.push_back(o);
    endtask

    initial begin
        obs_t x, a;
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                a.illd = cpif.IllegalD;   a.imm = cpif.ImmSrcD;
                a.alu = cpif.ALUControlE; a.asrc = cpif.ALUSrcE; a.pcsrc = cpif.SrcAsrcE;
                a.br = cpif.BranchE;      a.j = cpif.JumpE;      a.jr = cpif.jumpRegE;
                a.f3e = cpif.funct3E;     a.busy = cpif.MDBusy;
                a.rwm = cpif.RegWriteM;   a.mwm = cpif.MemWriteM;
                a.rsm = cpif.ResultSrcM;  a.f3m = cpif.funct3M;
                a.rww = cpif.RegWriteW;   a.rsw = cpif.ResultSrcW; a.illw = cpif.IllegalW;
                n_tests++;
                if (a !== x) begin
                    n_fail++;
                    $display("FAIL outputs cycle %0d: got %h required %h (busy %b/%b rwm %b/%b illw %b/%b)",
                             cyc, a, x, a.busy, x.busy, a.rwm, x.rwm, a.illw, x.illw);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: run did not finish, %0d expectations pending", exp_q.size());
        $fatal(1);
    end

    localparam logic [31:0] ADD = 32'h003100B3;
    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [31:0] SW  = 32'h00112223;
    localparam logic [31:0] BAD = 32'h0000007F;
    localparam logic [31:0] MUL = 32'h02A302B3;
    localparam logic [31:0] DIV = 32'h027342B3;

    initial begin
        reset = 1'b1;
        cpif.InstrD = ADD; cpif.StallE = 1'b0; cpif.FlushE = 1'b0;
        cur_ins = ADD; cur_st = 1'b0; cur_fl = 1'b0; cur_rst = 1'b1;
        model_clear();

        repeat (3) cycle(ADD, 0, 0, 1);
        repeat (20) cycle(rand_instr(), 0, 0, 0);
        // reset lands mid-stream, then a lone add
        repeat (2) cycle(ADD, 0, 0, 1);
        cycle(ADD, 0, 0, 0);
        repeat (4) cycle(NOP, 0, 0, 0);

        cycle(SW, 0, 0, 0);
        cycle(BAD, 0, 0, 0);
        repeat (4) cycle(NOP, 0, 0, 0);

        cycle(MUL, 0, 0, 0);
        repeat (4) cycle(NOP, 0, 0, 0);

        if (MEXT) begin
            cycle(DIV, 0, 0, 0);
            repeat (9) cycle(NOP, 0, 0, 0);
            repeat (13) cycle(DIV, 0, 0, 0);
            repeat (9) cycle(NOP, 0, 0, 0);
            cycle(DIV, 0, 0, 0);
            repeat (2) cycle(NOP, 0, 0, 0);
            cycle(NOP, 0, 1, 0);
            repeat (6) cycle(NOP, 0, 0, 0);
        end

        for (int i = 0; i < 400; i++)
            cycle(rand_instr(), $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
                  $urandom_range(0, 99) == 0);
        repeat (8) cycle(NOP, 0, 0, 0);

        repeat (3) @(posedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ctrl_pipeline.md
Name: ctrl_pipeline

Overview:
- Second-generation control unit for the 5-stage RV32 core.
- Decodes the D-stage instruction into a control bundle and carries it through its own E, M and W pipeline registers, with stall and flush per stage.
- Adds illegal-instruction detection.
- Adds an optional M-extension sequencer: a multi-cycle divide FSM that freezes E and back-pressures the hazard unit.

Parameters:
- DIV_LATENCY, 32, number of BUSY cycles for DIV/DIVU/REM/REMU; legal range 1..64.
- CNT_W, $clog2(DIV_LATENCY+1), width of the divide counter.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- InstrD  in  32  D-stage instruction
- StallE  in  1  hold the E register
- FlushE  in  1  bubble the E register
- ALUControlE  out  5  E-stage ALU op
- ALUSrcE, SrcAsrcE, BranchE, JumpE, jumpRegE  out  1 each  E-stage control
- ImmSrcD  out  3  D-stage immediate select (combinational)
- funct3E  out  3  funct3 carried to E
- MDBusy  out  1  divide in progress; hazard unit must stall F/D/E
- RegWriteM, MemWriteM  out  1 each  M-stage control
- ResultSrcM  out  2  M-stage result select
- funct3M  out  3  funct3 carried to M
- RegWriteW  out  1  W-stage register write
- ResultSrcW  out  2  W-stage result select
- IllegalD  out  1  D-stage illegal instruction (combinational)
- IllegalW  out  1  illegal instruction retiring in W

Behaviour:
- Decode (combinational, D stage):
  - Opcodes: lw, sw, R-type, I-ALU, beq-class, jal, jalr, lui, auipc.
  - Any other opcode sets IllegalD=1 and forces RegWrite/MemWrite/Branch/Jump to 0.
  - ALUControl encodings: ADD 00000, SUB 00001, AND 00010, OR 00011, XOR 00100, SLT 00101, SLTU 00110, SLL 00111, SRL 01000, SRA 01001, PASSB 01010 (lui).
  - M-extension ops are encoded as {2'b10, funct3}.
- E register:
  - Loads the D bundle each cycle unless StallE=1 or MDBusy=1.
  - FlushE=1 loads a bubble (all enables 0, ALUControl 0, IllegalE 0).
  - FlushE has priority over both StallE and MDBusy.
- M and W registers:
  - Advance every cycle.
  - M loads a bubble while MDBusy=1.
- Reset: every register output is 0 and the FSM goes to IDLE. This applies immediately, including mid-divide.
- Divide FSM (states IDLE, BUSY, DONE):
  - divE = E holds R-type with funct7=0000001 and funct3[2]=1.
  - IDLE: if divE and no FlushE, load cnt=DIV_LATENCY-1 and go to BUSY.
  - BUSY: if cnt≠0, decrement cnt; if cnt=0, go to DONE.
  - DONE: go to IDLE; the E register advances this cycle.
  - MDBusy = (IDLE & divE) | BUSY. It is combinational and deasserted in DONE.
  - A divide occupies E for DIV_LATENCY+2 cycles. MDBusy is high for DIV_LATENCY+1 of them.
  - MUL/MULH/MULHSU/MULHU are single-cycle: no busy, no FSM activity.
  - FlushE in BUSY or DONE aborts the divide: FSM goes to IDLE, E gets a bubble, MDBusy=0 the next cycle.
  - Back-to-back divides: the second divide enters E after DONE, sees IDLE with divE, and restarts. There is no idle gap between the two MDBusy windows other than the DONE cycle.
- StallE during BUSY has no additional effect.

Optional Feature:
- Macro: RV_M_EXT_EN.
- Defined: M decode and the divide FSM as above.
- Undefined:
  - R-type with funct7=0000001 sets IllegalD=1.
  - No FSM is built.
  - MDBusy is tied to 0.
  - ALUControlE[4:3] is never 10.

Test Plan:
- Reset asserted mid-stream, then `add x1,x2,x3` (0x003100B3) -> all outputs 0 during reset; after release, ALUControlE=00000 one cycle later, RegWriteM=1 two cycles later, RegWriteW=1 three cycles later.
- `sw` followed by an opcode 0x7F instruction -> MemWriteM=1 for the sw. The bad opcode gives IllegalD=1 and IllegalW=1 three cycles later, with RegWriteW=0.
- DIV_LATENCY=4, `div x5,x6,x7` -> MDBusy high for 5 consecutive cycles; E holds for 6 cycles; RegWriteM=0 for 5 cycles, then 1.
- `div` followed by a second `div` -> two MDBusy windows of 5 cycles each, separated by exactly one low cycle (the DONE cycle).
- FlushE pulsed on the 2nd BUSY cycle -> MDBusy=0 the next cycle, E is a bubble, and the divide never reaches M.
- With RV_M_EXT_EN undefined, `mul` (0x02A302B3) -> IllegalD=1, MDBusy=0, RegWriteW=0.
